// File: rtl/execute_flag_condition_unit.sv
// rtl/execute_flag_condition_unit.sv - branch condition evaluation against scoreboarded flags
// Stalls a branch until all older flag writes are final, using the commit bypass when one remains.
module execute_flag_condition_unit #(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 3
) (
  input  logic                iCLOCK,
  input  logic                iRESET_SYNC,
  input  logic                iCTRL_HOLD,
  input  logic                iPIPE_FLUSH,
  input  logic [4:0]          iFLAG,
  input  logic                iFLAG_ISSUE,
  input  logic                iFLAG_COMMIT,
  input  logic [4:0]          iFWD_FLAG,
  output logic                oPENDING_FULL,
  input  logic                iPREV_INST_VALID,
  output logic                oPREV_BUSY,
  input  logic [3:0]          iPREV_CC,
  input  logic [PC_WIDTH-1:0] iPREV_PC,
  input  logic [PC_WIDTH-1:0] iPREV_TARGET,
  output logic                oNEXT_VALID,
  input  logic                iNEXT_BUSY,
  output logic                oNEXT_TAKEN,
  output logic [PC_WIDTH-1:0] oNEXT_PC
);

  typedef enum logic {ST_IDLE, ST_WAIT} stateT;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  stateT                state, stateNext;
  logic [CNT_WIDTH-1:0] pendCnt, pendCntNext;
  logic [3:0]           ccReg;
  logic [PC_WIDTH-1:0]  pcReg, targetReg;

  logic                 outFree, bypassHit, resolvable, accept, load, latch, taken;
  logic [4:0]           effFlag;
  logic [3:0]           selCc;
  logic [PC_WIDTH-1:0]  selPc, selTarget, loadPc;

  function automatic logic condMet(input logic [3:0] cc, input logic [4:0] f);
    logic z, s, c, o, p;
    z = f[0]; s = f[1]; c = f[2]; o = f[3]; p = f[4];
    case (cc)
      4'd0:    condMet = 1'b1;
      4'd1:    condMet = z;
      4'd2:    condMet = !z;
      4'd3:    condMet = c;
      4'd4:    condMet = !c;
      4'd5:    condMet = s;
      4'd6:    condMet = !s;
      4'd7:    condMet = o;
      4'd8:    condMet = !o;
      4'd9:    condMet = c & !z;
      4'd10:   condMet = !c | z;
      4'd11:   condMet = (s == o);
      4'd12:   condMet = (s != o);
      4'd13:   condMet = !z & (s == o);
      4'd14:   condMet = z | (s != o);
      default: condMet = p;
    endcase
  endfunction

  assign oPENDING_FULL = (pendCnt == CNT_MAX);
  assign oPREV_BUSY    = (state == ST_WAIT) || (oNEXT_VALID && iNEXT_BUSY);
  assign outFree       = !oNEXT_VALID || !iNEXT_BUSY;

  // Pre-update counter: a flag op issuing this cycle is younger than the branch.
  assign bypassHit  = (pendCnt == CNT_ONE) && iFLAG_COMMIT;
  assign effFlag    = bypassHit ? iFWD_FLAG : iFLAG;
  assign selCc      = (state == ST_WAIT) ? ccReg     : iPREV_CC;
  assign selPc      = (state == ST_WAIT) ? pcReg     : iPREV_PC;
  assign selTarget  = (state == ST_WAIT) ? targetReg : iPREV_TARGET;
  assign resolvable = (selCc == 4'd0) || (pendCnt == '0) || bypassHit;
  assign accept     = (state == ST_IDLE) && iPREV_INST_VALID && !oPREV_BUSY;
  assign taken      = condMet(selCc, effFlag);
  assign loadPc     = taken ? selTarget : selPc + PC_WIDTH'(4);

  always_comb begin
    stateNext = state;
    load      = 1'b0;
    latch     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          latch = 1'b1;
          if (resolvable && outFree) load = 1'b1;
          else                       stateNext = ST_WAIT;
        end
      end
      default: begin
        if (resolvable && outFree) begin
          load      = 1'b1;
          stateNext = ST_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    pendCntNext = pendCnt;
    case ({iFLAG_ISSUE, iFLAG_COMMIT})
      2'b10:   if (pendCnt != CNT_MAX) pendCntNext = pendCnt + CNT_ONE;
      2'b01:   if (pendCnt != '0)      pendCntNext = pendCnt - CNT_ONE;
      default: pendCntNext = pendCnt;
    endcase
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC || iPIPE_FLUSH) begin
      state       <= ST_IDLE;
      pendCnt     <= '0;
      ccReg       <= '0;
      pcReg       <= '0;
      targetReg   <= '0;
      oNEXT_VALID <= 1'b0;
      oNEXT_TAKEN <= 1'b0;
      oNEXT_PC    <= '0;
    end else if (!iCTRL_HOLD) begin
      state   <= stateNext;
      pendCnt <= pendCntNext;
      if (latch) begin
        ccReg     <= iPREV_CC;
        pcReg     <= iPREV_PC;
        targetReg <= iPREV_TARGET;
      end
      if (load) begin
        oNEXT_VALID <= 1'b1;
        oNEXT_TAKEN <= taken;
        oNEXT_PC    <= loadPc;
      end else if (!iNEXT_BUSY) begin
        oNEXT_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_execute_flag_condition_unit.sv
// tb/tb_execute_flag_condition_unit.sv - randomized + directed bench against a behavioural model
module tb_execute_flag_condition_unit;

  logic        iCLOCK = 1'b0;
  logic        iRESET_SYNC = 1'b1, iCTRL_HOLD = 1'b0, iPIPE_FLUSH = 1'b0;
  logic [4:0]  iFLAG = '0, iFWD_FLAG = '0;
  logic        iFLAG_ISSUE = 1'b0, iFLAG_COMMIT = 1'b0;
  logic        oPENDING_FULL, oPREV_BUSY, oNEXT_VALID, oNEXT_TAKEN;
  logic        iPREV_INST_VALID = 1'b0, iNEXT_BUSY = 1'b0;
  logic [3:0]  iPREV_CC = '0;
  logic [31:0] iPREV_PC = '0, iPREV_TARGET = '0, oNEXT_PC;

  int nChecks = 0, nFails = 0;
  bit armed = 0;

  // Behavioural model state
  int          mCnt;
  bit          mWaiting;
  int          mCc;
  bit [31:0]   mPc, mTarget;
  bit          mValid, mTaken;
  bit [31:0]   mOutPc;

  execute_flag_condition_unit dut (
    .iCLOCK(iCLOCK), .iRESET_SYNC(iRESET_SYNC), .iCTRL_HOLD(iCTRL_HOLD),
    .iPIPE_FLUSH(iPIPE_FLUSH), .iFLAG(iFLAG), .iFLAG_ISSUE(iFLAG_ISSUE),
    .iFLAG_COMMIT(iFLAG_COMMIT), .iFWD_FLAG(iFWD_FLAG), .oPENDING_FULL(oPENDING_FULL),
    .iPREV_INST_VALID(iPREV_INST_VALID), .oPREV_BUSY(oPREV_BUSY), .iPREV_CC(iPREV_CC),
    .iPREV_PC(iPREV_PC), .iPREV_TARGET(iPREV_TARGET), .oNEXT_VALID(oNEXT_VALID),
    .iNEXT_BUSY(iNEXT_BUSY), .oNEXT_TAKEN(oNEXT_TAKEN), .oNEXT_PC(oNEXT_PC)
  );

  always #5 iCLOCK = ~iCLOCK;

  function automatic bit modelCond(int cc, bit [4:0] f);
    bit z, s, c, o, p;
    z = f[0]; s = f[1]; c = f[2]; o = f[3]; p = f[4];
    case (cc)
      0: return 1;        1: return z;          2: return !z;
      3: return c;        4: return !c;         5: return s;
      6: return !s;       7: return o;          8: return !o;
      9: return c && !z;  10: return !c || z;   11: return s == o;
      12: return s != o;  13: return !z && (s == o);
      14: return z || (s != o);
      default: return p;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareModel();
    chk("model_valid", 32'(oNEXT_VALID), 32'(mValid));
    if (mValid) begin
      chk("model_taken", 32'(oNEXT_TAKEN), 32'(mTaken));
      chk("model_pc", oNEXT_PC, mOutPc);
    end
    chk("model_full", 32'(oPENDING_FULL), 32'(mCnt == 7));
    chk("model_busy", 32'(oPREV_BUSY), 32'(mWaiting || (mValid && iNEXT_BUSY)));
  endtask

  task automatic modelStep();
    bit outFree, bypass, busyNow, load, tk;
    int useCc;
    bit [31:0] usePc, useTgt;
    bit [4:0] eff;
    if (iRESET_SYNC || iPIPE_FLUSH) begin
      mCnt = 0; mWaiting = 0; mValid = 0; mTaken = 0; mOutPc = 0;
      return;
    end
    if (iCTRL_HOLD) return;
    outFree = !mValid || !iNEXT_BUSY;
    busyNow = mWaiting || (mValid && iNEXT_BUSY);
    bypass  = (mCnt == 1) && iFLAG_COMMIT;
    eff     = bypass ? iFWD_FLAG : iFLAG;
    load    = 0;
    useCc = mCc; usePc = mPc; useTgt = mTarget;
    if (mWaiting) begin
      if ((mCc == 0 || mCnt == 0 || bypass) && outFree) begin
        load = 1; mWaiting = 0;
      end
    end else if (iPREV_INST_VALID && !busyNow) begin
      useCc = int'(iPREV_CC); usePc = iPREV_PC; useTgt = iPREV_TARGET;
      if ((useCc == 0 || mCnt == 0 || bypass) && outFree) load = 1;
      else begin
        mWaiting = 1; mCc = useCc; mPc = usePc; mTarget = useTgt;
      end
    end
    if (load) begin
      tk = modelCond(useCc, eff);
      mValid = 1; mTaken = tk;
      mOutPc = tk ? useTgt : 32'((longint'(usePc) + 4) % 64'h1_0000_0000);
    end else if (!iNEXT_BUSY) mValid = 0;
    if (iFLAG_ISSUE && !iFLAG_COMMIT && mCnt < 7) mCnt++;
    else if (!iFLAG_ISSUE && iFLAG_COMMIT && mCnt > 0) mCnt--;
  endtask

  task automatic tick();
    @(negedge iCLOCK);
    if (armed) compareModel();
    @(posedge iCLOCK);
    modelStep();
    #1;
  endtask

  task automatic branch(int cc, logic [4:0] f, logic [31:0] pc, logic [31:0] tgt);
    iPREV_INST_VALID = 1; iPREV_CC = 4'(cc); iFLAG = f; iPREV_PC = pc; iPREV_TARGET = tgt;
    tick();
    iPREV_INST_VALID = 0;
  endtask

  initial begin
    iRESET_SYNC = 1;
    tick();
    iRESET_SYNC = 0;
    armed = 1;
    chk("reset_valid", 32'(oNEXT_VALID), 0);
    chk("reset_taken", 32'(oNEXT_TAKEN), 0);
    chk("reset_pc", oNEXT_PC, 0);
    chk("reset_full", 32'(oPENDING_FULL), 0);
    chk("reset_busy", 32'(oPREV_BUSY), 0);

    // Immediate resolve, latency 1
    branch(1, 5'b00001, 32'h100, 32'h200);
    chk("t1_valid", 32'(oNEXT_VALID), 1);
    chk("t1_taken", 32'(oNEXT_TAKEN), 1);
    chk("t1_pc", oNEXT_PC, 32'h200);

    // Wait on one pending write, resolve through the bypass
    iFLAG_ISSUE = 1; tick(); iFLAG_ISSUE = 0;
    branch(2, 5'b00001, 32'h140, 32'h300);
    chk("t2_busy", 32'(oPREV_BUSY), 1);
    chk("t2_novalid", 32'(oNEXT_VALID), 0);
    iFLAG_COMMIT = 1; iFWD_FLAG = 5'b00000; tick(); iFLAG_COMMIT = 0;
    chk("t2_valid", 32'(oNEXT_VALID), 1);
    chk("t2_taken", 32'(oNEXT_TAKEN), 1);
    chk("t2_pc", oNEXT_PC, 32'h300);

    // Not taken with PC wrap
    branch(11, 5'b00010, 32'hFFFF_FFFC, 32'h400);
    chk("t3_taken", 32'(oNEXT_TAKEN), 0);
    chk("t3_pc", oNEXT_PC, 32'h0);

    // Counter saturation and floor
    iFLAG_ISSUE = 1;
    for (int i = 0; i < 7; i++) tick();
    chk("t4_full7", 32'(oPENDING_FULL), 1);
    tick();
    chk("t4_full8", 32'(oPENDING_FULL), 1);
    iFLAG_COMMIT = 1; tick();
    chk("t4_both", 32'(oPENDING_FULL), 1);
    iFLAG_ISSUE = 0;
    for (int i = 0; i < 8; i++) tick();
    chk("t4_drain", 32'(oPENDING_FULL), 0);
    iFLAG_COMMIT = 0;
    branch(1, 5'b00000, 32'h500, 32'h600);
    chk("t4_zero_valid", 32'(oNEXT_VALID), 1);
    chk("t4_zero_pc", oNEXT_PC, 32'h504);

    // Downstream backpressure
    branch(0, 5'b00000, 32'h700, 32'h800);
    iNEXT_BUSY = 1; iPREV_INST_VALID = 1; iPREV_CC = 0; iPREV_PC = 32'h900; iPREV_TARGET = 32'hA00;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_busy", 32'(oPREV_BUSY), 1);
      chk("t5_stable_pc", oNEXT_PC, 32'h800);
      chk("t5_stable_valid", 32'(oNEXT_VALID), 1);
    end
    iNEXT_BUSY = 0; tick(); iPREV_INST_VALID = 0;
    chk("t5_accept_pc", oNEXT_PC, 32'hA00);

    // Flush during WAIT
    iFLAG_ISSUE = 1; tick(); iFLAG_ISSUE = 0;
    branch(1, 5'b00001, 32'hB00, 32'hC00);
    chk("t6_wait", 32'(oPREV_BUSY), 1);
    iPIPE_FLUSH = 1; tick(); iPIPE_FLUSH = 0;
    chk("t6_flush_busy", 32'(oPREV_BUSY), 0);
    chk("t6_flush_valid", 32'(oNEXT_VALID), 0);
    tick();
    chk("t6_no_output", 32'(oNEXT_VALID), 0);

    // Hold during WAIT with commit asserted
    iFLAG_ISSUE = 1; tick(); iFLAG_ISSUE = 0;
    branch(1, 5'b00001, 32'hD00, 32'hE00);
    iCTRL_HOLD = 1; iFLAG_COMMIT = 1; iFWD_FLAG = 5'b00001;
    tick(); tick();
    chk("t7_hold_busy", 32'(oPREV_BUSY), 1);
    chk("t7_hold_valid", 32'(oNEXT_VALID), 0);
    iCTRL_HOLD = 0; tick(); iFLAG_COMMIT = 0;
    chk("t7_release_valid", 32'(oNEXT_VALID), 1);
    chk("t7_release_pc", oNEXT_PC, 32'hE00);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      iRESET_SYNC      = ($urandom_range(0, 199) == 0);
      iPIPE_FLUSH      = ($urandom_range(0, 49) == 0);
      iCTRL_HOLD       = ($urandom_range(0, 15) == 0);
      iFLAG_ISSUE      = ($urandom_range(0, 2) == 0);
      iFLAG_COMMIT     = ($urandom_range(0, 2) == 0);
      iFLAG            = 5'($urandom);
      iFWD_FLAG        = 5'($urandom);
      iPREV_INST_VALID = $urandom_range(0, 1) == 1;
      iPREV_CC         = 4'($urandom);
      iPREV_PC         = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : {$urandom} & 32'hFFFF_FFFC;
      iPREV_TARGET     = $urandom;
      iNEXT_BUSY       = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/execute_flag_condition_unit.md
Name: execute_flag_condition_unit

Overview:
- Consumer side of the execute-stage flag register: evaluates conditional branches against the 5-bit flag value.
- Tracks in-flight flag-writing ops with a scoreboard counter and stalls a branch until its flags are final.
- Takes the committing value from the flag bypass instead of waiting an extra cycle.
- Sits between branch issue (upstream valid/busy) and fetch redirect (downstream valid/busy).

Parameters:
- PC_WIDTH, 32, width of PC and target.
- CNT_WIDTH, 3, width of the outstanding flag-write counter; maximum count is 2^CNT_WIDTH-1.

Ports:
- iCLOCK  in  1  clock; all logic on rising edge.
- iRESET_SYNC  in  1  synchronous active-high reset.
- iCTRL_HOLD  in  1  freeze all state.
- iPIPE_FLUSH  in  1  pipeline flush.
- iFLAG  in  5  committed flag register value; bit0 Z, bit1 S, bit2 C, bit3 O, bit4 P.
- iFLAG_ISSUE  in  1  flag-writing op entered execute.
- iFLAG_COMMIT  in  1  flag write committing this cycle.
- iFWD_FLAG  in  5  value being committed; valid when iFLAG_COMMIT=1.
- oPENDING_FULL  out  1  counter at maximum; upstream must not issue.
- iPREV_INST_VALID  in  1  branch request valid.
- oPREV_BUSY  out  1  cannot accept.
- iPREV_CC  in  4  condition code.
- iPREV_PC  in  PC_WIDTH  branch PC.
- iPREV_TARGET  in  PC_WIDTH  taken target.
- oNEXT_VALID  out  1  result valid.
- iNEXT_BUSY  in  1  downstream stall.
- oNEXT_TAKEN  out  1  condition met.
- oNEXT_PC  out  PC_WIDTH  next PC.

Behaviour:
- Priority: iRESET_SYNC > iPIPE_FLUSH > iCTRL_HOLD > normal operation.
- Reset and flush clear: counter, state (to IDLE), latched instruction, oNEXT_VALID, oNEXT_TAKEN, oNEXT_PC. All outputs are 0 after reset.
- iCTRL_HOLD keeps every register unchanged.
- Counter update:
  - ISSUE only: +1. Saturates at max; further ISSUE is ignored.
  - COMMIT only: -1. Ignored at 0.
  - ISSUE and COMMIT together: counter unchanged.
- oPENDING_FULL = (counter == max), combinational.
- Condition decode (Z,S,C,O,P):
  - 0 ALWAYS; 1 Z; 2 !Z; 3 C; 4 !C; 5 S; 6 !S; 7 O; 8 !O.
  - 9 C&!Z; 10 !C|Z; 11 S==O; 12 S!=O.
  - 13 !Z&(S==O); 14 Z|(S!=O); 15 P.
- Effective flags:
  - iFWD_FLAG when counter==1 and iFLAG_COMMIT=1.
  - Otherwise iFLAG.
  - Only meaningful when the branch is resolvable.
- Resolvable = cc==0, or counter==0, or (counter==1 and iFLAG_COMMIT). Always uses the pre-update counter, so a same-cycle iFLAG_ISSUE is a younger op and never blocks.
- out_free = !oNEXT_VALID or !iNEXT_BUSY.
- oPREV_BUSY = (state==WAIT) or (oNEXT_VALID and iNEXT_BUSY).
- States:
  - IDLE: on iPREV_INST_VALID and !oPREV_BUSY, latch cc/pc/target. If resolvable and out_free, load the output next cycle (latency 1) and stay in IDLE. Otherwise go to WAIT.
  - WAIT: each cycle re-evaluate the latched instruction. When resolvable and out_free, load the output and go to IDLE.
- Output load:
  - oNEXT_VALID=1.
  - oNEXT_TAKEN = condition.
  - oNEXT_PC = taken ? target : pc+4, modulo 2^PC_WIDTH.
- oNEXT_VALID clears on a cycle with !iNEXT_BUSY when no new load occurs. Outputs are stable while oNEXT_VALID and iNEXT_BUSY.
- Back-to-back accepts without bubbles when downstream is not busy and the branches are resolvable.
- A flush during WAIT discards the branch; no output is produced.

Test Plan:
- Reset, then counter=0; cc=1 with iFLAG=5'b00001, pc=0x100, target=0x200 -> next cycle oNEXT_VALID=1, TAKEN=1, PC=0x200.
- iFLAG_ISSUE once, then branch cc=2 with iFLAG=Z=1 -> WAIT and oPREV_BUSY=1. Commit with iFWD_FLAG=0 -> resolves that cycle; next cycle TAKEN=1, PC=target.
- Branch cc=11, iFLAG S=1 O=0, counter=0 -> TAKEN=0, oNEXT_PC=pc+4. With pc=0xFFFFFFFC -> oNEXT_PC=0x00000000.
- Issue 7 times (CNT_WIDTH=3) -> oPENDING_FULL=1; an 8th issue leaves the counter at 7. Issue and commit together -> stays 7. Commit with counter 0 -> stays 0.
- Output valid with iNEXT_BUSY=1 for 3 cycles -> outputs stable, oPREV_BUSY=1, new request not accepted. Drop busy -> request accepted.
- Branch waiting in WAIT, then iPIPE_FLUSH -> counter=0, state IDLE, oNEXT_VALID=0, no output. iCTRL_HOLD during WAIT with commit asserted -> no state or counter change.
